// File: rtl/project_types.sv
// Shared fetch-path types: instruction/address element types and the
// prefetch queue entry layout.
package project_types;

  localparam int INST_BYTES = 4;

  typedef logic [31:0] inst_addr_t;
  typedef logic [31:0] inst_t;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
    logic       filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: pipelined in-order fetch requests, PC-tagged
// buffering toward decode, and redirect flush with stale-response discard.
module fetch_queue
  import project_types::*;
#(
  parameter int unsigned       DEPTH           = 4,
  parameter int unsigned       MAX_OUTSTANDING = 2,
  parameter int unsigned       ADDR_W          = 32,
  parameter int unsigned       DATA_W          = 32,
  parameter logic [ADDR_W-1:0] RESET_PC        = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_inst_o,
  output logic [ADDR_W-1:0] out_pc_o,
  input  logic              out_ready_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int DC_W  = $clog2(MAX_OUTSTANDING + 1) + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CNT_W-1:0]  alloc_q, alloc_d, outst_q, outst_d;
  logic [DC_W-1:0]   disc_q, disc_d;

  logic [DEPTH-1:0][ADDR_W-1:0] pc_q;
  logic [DEPTH-1:0][DATA_W-1:0] inst_q;
  logic [DEPTH-1:0]             filled_q;

  logic grant, rsp_fill, rsp_drop, pop, rsp_counted;
  logic unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc_i[1:0];

  // Gated by rst so the request drops the instant reset asserts.
  assign mem_req_o   = rst && !redirect_i &&
                       (alloc_q < CNT_W'(DEPTH)) &&
                       (outst_q < CNT_W'(MAX_OUTSTANDING));
  assign mem_addr_o  = fetch_pc_q;
  assign out_valid_o = filled_q[head_q];
  assign out_inst_o  = inst_q[head_q];
  assign out_pc_o    = pc_q[head_q];

  assign grant       = mem_req_o && mem_gnt_i;
  assign rsp_drop    = mem_rvalid_i && (disc_q != '0);
  assign rsp_fill    = mem_rvalid_i && (disc_q == '0) && (outst_q != '0);
  assign pop         = out_valid_o && out_ready_i && !redirect_i;
  assign rsp_counted = mem_rvalid_i && ((disc_q != '0) || (outst_q != '0));

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    alloc_d    = alloc_q;
    outst_d    = outst_q;
    disc_d     = disc_q;
    if (redirect_i) begin
      // Everything in flight becomes stale; a response this cycle is one of them.
      head_d     = tail_q;
      fill_d     = tail_q;
      alloc_d    = '0;
      outst_d    = '0;
      disc_d     = disc_q + DC_W'(outst_q) - DC_W'(rsp_counted);
      fetch_pc_d = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    end else begin
      if (grant) begin
        tail_d     = tail_q + 1'b1;
        fetch_pc_d = fetch_pc_q + ADDR_W'(INST_BYTES);
      end
      if (rsp_fill) fill_d = fill_q + 1'b1;
      if (rsp_drop) disc_d = disc_q - 1'b1;
      if (pop)      head_d = head_q + 1'b1;
      alloc_d = alloc_q + CNT_W'(grant) - CNT_W'(pop);
      outst_d = outst_q + CNT_W'(grant) - CNT_W'(rsp_fill);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      alloc_q    <= '0;
      outst_q    <= '0;
      disc_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      alloc_q    <= alloc_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
    end
  end

  // Grant, fill and pop never hit the same slot: tail is unreserved,
  // fill is reserved-but-empty, head is filled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= '0;
      inst_q   <= '0;
      filled_q <= '0;
    end else if (redirect_i) begin
      filled_q <= '0;
    end else begin
      if (grant) begin
        pc_q[tail_q]     <= fetch_pc_q;
        filled_q[tail_q] <= 1'b0;
      end
      if (rsp_fill) begin
        inst_q[fill_q]   <= mem_rdata_i;
        filled_q[fill_q] <= 1'b1;
      end
      if (pop) filled_q[head_q] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a bench-side in-order memory model.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        out_valid_o;
  logic [31:0] out_inst_o;
  logic [31:0] out_pc_o;
  logic        out_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  int          errs = 0;
  int          checks = 0;
  bit          auto_mem = 1'b0;
  logic [31:0] pend[$];

  fetch_queue dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .out_valid_o  (out_valid_o),
    .out_inst_o   (out_inst_o),
    .out_pc_o     (out_pc_o),
    .out_ready_i  (out_ready_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory model: records granted addresses; data returned is ~addr.
  // In auto mode each grant is answered the following cycle.
  task automatic tick();
    logic        g;
    logic [31:0] a;
    g = mem_req_o && mem_gnt_i;
    a = mem_addr_o;
    @(posedge clk);
    #1;
    if (g) pend.push_back(a);
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    if (auto_mem && pend.size() > 0) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = ~pend.pop_front();
    end
  endtask

  task automatic rsp();
    checks++;
    assert (pend.size() > 0) else begin
      errs++;
      $error("FAIL rsp_protocol: observed=%0d pending expected=>0", pend.size());
    end
    if (pend.size() > 0) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = ~pend.pop_front();
    end
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    mem_gnt_i     = 1'b0;
    mem_rvalid_i  = 1'b0;
    mem_rdata_i   = '0;
    out_ready_i   = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    pend.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    out_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    #2;
    chk("rst_req",   {31'd0, mem_req_o},   32'd0);
    chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_inst",  out_inst_o,           32'd0);
    chk("rst_pc",    out_pc_o,             32'd0);
    chk("rst_addr",  mem_addr_o,           32'd0);

    // Streaming: one instruction per cycle, two cycles after first request.
    do_reset(); auto_mem = 1; mem_gnt_i = 1; out_ready_i = 1;
    for (int n = 0; n < 8; n++) begin
      #1;
      chk($sformatf("stream_addr%0d", n), mem_addr_o, 32'(4 * n));
      chk($sformatf("stream_req%0d", n), {31'd0, mem_req_o}, 32'd1);
      if (n >= 2) begin
        chk($sformatf("stream_pc%0d", n),   out_pc_o,   32'(4 * (n - 2)));
        chk($sformatf("stream_inst%0d", n), out_inst_o, ~32'(4 * (n - 2)));
      end else
        chk($sformatf("stream_valid%0d", n), {31'd0, out_valid_o}, 32'd0);
      tick();
    end

    // Stalled decode: exactly DEPTH grants, then drain in order.
    do_reset(); auto_mem = 1; mem_gnt_i = 1; out_ready_i = 0;
    for (int n = 0; n < 6; n++) begin
      #1;
      if (n < 4) begin
        chk($sformatf("hold_req%0d", n),  {31'd0, mem_req_o}, 32'd1);
        chk($sformatf("hold_addr%0d", n), mem_addr_o, 32'(4 * n));
      end else
        chk($sformatf("hold_req%0d", n), {31'd0, mem_req_o}, 32'd0);
      if (n >= 2) chk($sformatf("hold_pc%0d", n), out_pc_o, 32'd0);
      tick();
    end
    out_ready_i = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("drain_valid%0d", k), {31'd0, out_valid_o}, 32'd1);
      chk($sformatf("drain_pc%0d", k), out_pc_o, 32'(4 * k));
      if (k == 0) chk("drain_req0", {31'd0, mem_req_o}, 32'd0);
      if (k == 1) chk("drain_addr1", mem_addr_o, 32'h10);
      tick();
    end

    // Redirect with two outstanding: both stale responses dropped.
    do_reset(); auto_mem = 0; mem_gnt_i = 1; out_ready_i = 1;
    #1; chk("rd_addr0", mem_addr_o, 32'h0); tick();
    #1; chk("rd_addr1", mem_addr_o, 32'h4); tick();
    redirect_i = 1; redirect_pc_i = 32'h0000_0103;
    #1; chk("rd_req_redirect", {31'd0, mem_req_o}, 32'd0); tick();
    redirect_i = 0; rsp();
    #1; chk("rd_new_addr", mem_addr_o, 32'h100);
    chk("rd_new_req", {31'd0, mem_req_o}, 32'd1);
    chk("rd_valid3", {31'd0, out_valid_o}, 32'd0); tick();
    rsp();
    #1; chk("rd_valid4", {31'd0, out_valid_o}, 32'd0);
    chk("rd_addr4", mem_addr_o, 32'h104); tick();
    rsp();
    #1; chk("rd_valid5", {31'd0, out_valid_o}, 32'd0); tick();
    #1; chk("rd_out_valid", {31'd0, out_valid_o}, 32'd1);
    chk("rd_out_pc", out_pc_o, 32'h100);
    chk("rd_out_inst", out_inst_o, ~32'h100);

    // Redirect coinciding with a response and an attempted pop.
    do_reset(); auto_mem = 0; mem_gnt_i = 1; out_ready_i = 0;
    #1; chk("rr_addr0", mem_addr_o, 32'h0); tick();
    #1; chk("rr_addr1", mem_addr_o, 32'h4); tick();
    rsp();
    #1; chk("rr_req2", {31'd0, mem_req_o}, 32'd0); tick();
    #1; chk("rr_pc3", out_pc_o, 32'h0);
    chk("rr_addr3", mem_addr_o, 32'h8); tick();
    out_ready_i = 1; redirect_i = 1; redirect_pc_i = 32'h200; rsp();
    #1; chk("rr_valid4", {31'd0, out_valid_o}, 32'd1);
    chk("rr_req4", {31'd0, mem_req_o}, 32'd0); tick();
    redirect_i = 0; rsp();
    #1; chk("rr_valid5", {31'd0, out_valid_o}, 32'd0);
    chk("rr_addr5", mem_addr_o, 32'h200); tick();
    rsp();
    #1; chk("rr_valid6", {31'd0, out_valid_o}, 32'd0);
    chk("rr_addr6", mem_addr_o, 32'h204); tick();
    rsp();
    #1; chk("rr_valid7", {31'd0, out_valid_o}, 32'd1);
    chk("rr_pc7", out_pc_o, 32'h200);
    chk("rr_inst7", out_inst_o, ~32'h200); tick();
    #1; chk("rr_pc8", out_pc_o, 32'h204);
    chk("rr_inst8", out_inst_o, ~32'h204);

    // Fetch address wraps past the top of the address space.
    do_reset(); auto_mem = 1; mem_gnt_i = 1; out_ready_i = 1;
    redirect_i = 1; redirect_pc_i = 32'hFFFF_FFFC;
    #1; chk("wrap_req0", {31'd0, mem_req_o}, 32'd0); tick();
    redirect_i = 0;
    #1; chk("wrap_addr1", mem_addr_o, 32'hFFFF_FFFC); tick();
    #1; chk("wrap_addr2", mem_addr_o, 32'h0); tick();
    #1; chk("wrap_pc3", out_pc_o, 32'hFFFF_FFFC);
    chk("wrap_inst3", out_inst_o, 32'h3);

    // Asynchronous reset with requests outstanding.
    do_reset(); auto_mem = 0; mem_gnt_i = 1; out_ready_i = 0;
    #1; tick();
    rsp();
    #1; tick();
    #1; chk("ar_valid_pre", {31'd0, out_valid_o}, 32'd1);
    chk("ar_inst_pre", out_inst_o, 32'hFFFF_FFFF);
    chk("ar_addr_pre", mem_addr_o, 32'h8);
    rst = 1'b0;
    #1;
    chk("ar_req",   {31'd0, mem_req_o},   32'd0);
    chk("ar_valid", {31'd0, out_valid_o}, 32'd0);
    chk("ar_inst",  out_inst_o,           32'd0);
    chk("ar_pc",    out_pc_o,             32'd0);
    chk("ar_addr",  mem_addr_o,           32'd0);
    pend.delete(); mem_rvalid_i = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    chk("ar_post_req",  {31'd0, mem_req_o}, 32'd1);
    chk("ar_post_addr", mem_addr_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
